pc_reg: RTL and testbench

- Program-counter register for the processor datapath. Holds the current instruction address and drives it to the fetch stage.
- Loads a new address (next-PC mux output) on a rising clock edge when enabled. Otherwise it holds its value.
- Asynchronous active-low reset forces RESET_VALUE.
- Also provides the previous PC value and an alignment flag for exception logic.

---
 rtl/pc_reg_if.sv | 36 +++
 rtl/pc_reg.sv | 54 +++++
 tb/tb_pc_reg.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pc_reg_if.sv
// Bus bundle between the next-PC logic and the program-counter register.
// The inc strobe exists only when PC_INC_EN is defined.
interface pc_reg_if #(
    parameter int WIDTH = 32
);
    logic             enable;
    logic [WIDTH-1:0] datain;
    logic [WIDTH-1:0] dataout;
    logic [WIDTH-1:0] prev_pc;
    logic             misaligned;
`ifdef PC_INC_EN
    logic             inc;
`endif

    modport master (
        output enable,
        output datain,
`ifdef PC_INC_EN
        output inc,
`endif
        input  dataout,
        input  prev_pc,
        input  misaligned
    );

    modport slave (
        input  enable,
        input  datain,
`ifdef PC_INC_EN
        input  inc,
`endif
        output dataout,
        output prev_pc,
        output misaligned
    );
endinterface

// File: rtl/pc_reg.sv
// Program-counter register with previous-PC capture and alignment flag.
// Define PC_INC_EN to add a self-increment (bus.inc) path by INC_STEP.
module pc_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               ALIGN_BITS  = 2,
    parameter int               INC_STEP    = 4
) (
    input  logic     clk,
    input  logic     reset,
    pc_reg_if.slave  bus
);

    logic [WIDTH-1:0] pc_p0;
    logic [WIDTH-1:0] prev_p0;

`ifdef PC_INC_EN
    localparam logic [WIDTH-1:0] STEP = WIDTH'(INC_STEP);
`else
    // Keeps the increment amount referenced when the increment path is absent.
    localparam int UNUSED_STEP = INC_STEP;
    logic unused_step;
    assign unused_step = (UNUSED_STEP == 0);
`endif

    // Stage p0: loads gate strictly on a true 1 so an unknown strobe holds state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_p0   <= RESET_VALUE;
            prev_p0 <= RESET_VALUE;
        end else if (bus.enable == 1'b1) begin
            prev_p0 <= pc_p0;
            pc_p0   <= bus.datain;
        end
`ifdef PC_INC_EN
        else if (bus.inc == 1'b1) begin
            prev_p0 <= pc_p0;
            pc_p0   <= pc_p0 + STEP;
        end
`endif
    end

    assign bus.dataout = pc_p0;
    assign bus.prev_pc = prev_p0;

    generate
        if (ALIGN_BITS == 0) begin : g_no_align
            assign bus.misaligned = 1'b0;
        end else begin : g_align
            assign bus.misaligned = |pc_p0[ALIGN_BITS-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_pc_reg.sv
// Randomized self-checking bench for pc_reg against an arithmetic reference model.
module tb_pc_reg;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [W-1:0] m_pc;
    logic [W-1:0] m_prev;

    pc_reg_if #(.WIDTH(W)) bus ();

    pc_reg #(
        .WIDTH      (W),
        .RESET_VALUE('0),
        .ALIGN_BITS (2),
        .INC_STEP   (4)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/pc"}, bus.dataout, m_pc);
        check({tag, "/prev"}, bus.prev_pc, m_prev);
        check({tag, "/mis"}, {31'b0, bus.misaligned}, {31'b0, (m_pc % 4) != 0});
    endtask

    // Advance the model by the rules for one rising edge, then sample after it.
    task automatic tick(input string tag);
        if (!rst_n) begin
            m_pc   = '0;
            m_prev = '0;
        end else if (bus.enable === 1'b1) begin
            m_prev = m_pc;
            m_pc   = bus.datain;
        end
`ifdef PC_INC_EN
        else if (bus.inc === 1'b1) begin
            m_prev = m_pc;
            m_pc   = W'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        end
`endif
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        m_pc       = '0;
        m_prev     = '0;
        rst_n      = 1'b1;
        bus.enable = 1'b0;
        bus.datain = 32'd7;
`ifdef PC_INC_EN
        bus.inc    = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #50;
        check_all("reset_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick("reset_release");

        bus.enable = 1'b1;
        bus.datain = 32'd7;
        tick("load7");
        bus.datain = 32'd8;
        tick("load8");

        bus.enable = 1'b0;
        bus.datain = 32'd7;
        for (int i = 0; i < 3; i++) tick("hold");

        bus.enable = 1'b1;
        bus.datain = 32'd8;
        #2 rst_n = 1'b0;
        #1;
        m_pc   = '0;
        m_prev = '0;
        check_all("async_reset");
        tick("reset_dominant");
        tick("reset_dominant2");
        bus.enable = 1'b0;
        rst_n = 1'b1;
        tick("release_idle");

        bus.enable = 1'b1;
        bus.datain = 32'd7;
        tick("reload");

`ifdef PC_INC_EN
        bus.datain = 32'hFFFF_FFFC;
        tick("load_top");
        bus.enable = 1'b0;
        bus.inc    = 1'b1;
        tick("inc_wrap");
        bus.enable = 1'b1;
        bus.datain = 32'h40;
        tick("enable_over_inc");
        bus.inc    = 1'b0;
`endif

        for (int i = 0; i < 400; i++) begin
            bus.enable = ($urandom_range(0, 2) != 0);
            bus.datain = $urandom;
            if ($urandom_range(0, 1) == 0) bus.datain[1:0] = 2'b00;
`ifdef PC_INC_EN
            bus.inc = $urandom_range(0, 1) == 1;
`endif
            if (!rst_n && $urandom_range(0, 1) == 1) rst_n = 1'b1;
            if ($urandom_range(0, 24) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                m_pc   = '0;
                m_prev = '0;
                check_all("rand_async");
            end
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
